evacuate_ctrl: RTL and testbench

- Airlock evacuation controller.
- On request, with both doors sealed, it first bleeds chamber pressure (Depressurize), then pumps the chamber out (Evacuation) until the Evacuated sensor reports completion.
- Sits beside the pressurize controller under the airlock top level; sensor inputs come from the chamber, outputs drive the valve and pump.
- Moore FSM: all outputs are decoded from registered state.

---
 rtl/evacuate_ctrl_pkg.sv | 17 +
 rtl/evacuate_ctrl_phase_timer.sv | 35 +++
 rtl/evacuate_ctrl.sv | 108 ++++++++++
 tb/tb_evacuate_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/evacuate_ctrl_pkg.sv
// Shared airlock package.
// Holds the controller state enum (reused by the pressurize controller)
// and the default phase-timeout constants.
package evacuate_ctrl_pkg;

  localparam int unsigned DEFAULT_MAX_WAIT = 64;
  localparam int unsigned DEFAULT_CNT_W    = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEPRESS = 3'd1,
    EVAC    = 3'd2,
    DONE    = 3'd3,
    HOLD    = 3'd4
  } airlock_state_e;

endpackage

// File: rtl/evacuate_ctrl_phase_timer.sv
// Phase timer: saturating up-counter with synchronous clear and enable.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (clears the count)
//   clear   - synchronous clear, wins over enable
//   enable  - count up by one this cycle (stops at all-ones)
//   timeout - count has reached MAX_WAIT-1
module evacuate_ctrl_phase_timer
  import evacuate_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/evacuate_ctrl.sv
// Airlock evacuation controller (Moore FSM).
// With both doors sealed and a request held, bleeds chamber pressure
// (Depressurize) then pumps the chamber out (Evacuation) until the
// Evacuated sensor reports completion. Aborts and timeouts park in HOLD
// until the request is withdrawn.
// Ports:
//   Clock            - rising-edge system clock
//   Reset            - asynchronous active-low reset
//   begin_Evacuation - level request to evacuate
//   InnerClosed      - inner door closed and sealed
//   OuterClosed      - outer door closed and sealed
//   Pressurized      - chamber at elevated pressure
//   Evacuated        - chamber fully evacuated
//   Depressurize     - opens the bleed valve (DEPRESS only)
//   Evacuation       - runs the evacuation pump (EVAC only)
module evacuate_ctrl
  import evacuate_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_Evacuation,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Pressurized,
  input  logic Evacuated,
  output logic Depressurize,
  output logic Evacuation
);

  airlock_state_e state;
  airlock_state_e state_next;
  logic           sealed;
  logic           timeout;
  logic           active;

  assign sealed = InnerClosed & OuterClosed;
  assign active = (state == DEPRESS) || (state == EVAC);

  // The timer restarts on every state change, so each active phase gets
  // its own full MAX_WAIT budget.
  evacuate_ctrl_phase_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_phase_timer (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (state_next != state),
    .enable  (active),
    .timeout (timeout)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority in active phases: abort, then completion, then timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (begin_Evacuation && sealed) begin
          if (Evacuated) begin
            state_next = DONE;
          end else if (Pressurized) begin
            state_next = DEPRESS;
          end else begin
            state_next = EVAC;
          end
        end
      end
      DEPRESS: begin
        if (!sealed || !begin_Evacuation) begin
          state_next = HOLD;
        end else if (!Pressurized) begin
          state_next = EVAC;
        end else if (timeout) begin
          state_next = HOLD;
        end
      end
      EVAC: begin
        if (!sealed || !begin_Evacuation) begin
          state_next = HOLD;
        end else if (Evacuated) begin
          state_next = DONE;
        end else if (timeout) begin
          state_next = HOLD;
        end
      end
      DONE, HOLD: begin
        if (!begin_Evacuation) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Depressurize = (state == DEPRESS);
  assign Evacuation   = (state == EVAC);

endmodule

// File: tb/tb_evacuate_ctrl.sv
// Testbench for evacuate_ctrl: reset checks, a directed vector table,
// randomized stimulus against a behavioural model, and a mid-run reset.
module tb_evacuate_ctrl;

  localparam int unsigned MW = 4;

  logic Clock = 1'b0;
  logic Reset;
  logic b, ic, oc, pr, ev;
  logic dep, evac;

  always #5 Clock = ~Clock;

  evacuate_ctrl #(
    .MAX_WAIT (MW),
    .CNT_W    (7)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .begin_Evacuation (b),
    .InnerClosed      (ic),
    .OuterClosed      (oc),
    .Pressurized      (pr),
    .Evacuated        (ev),
    .Depressurize     (dep),
    .Evacuation       (evac)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Behavioural model: phase name plus cycles spent in the current phase.
  string phase = "idle";
  int    age   = 0;

  task automatic model_step();
    bit    sealed;
    string nxt;
    sealed = ic & oc;
    nxt    = phase;
    if (phase == "idle") begin
      if (b && sealed) nxt = ev ? "done" : (pr ? "bleed" : "pump");
    end else if (phase == "bleed" || phase == "pump") begin
      if (!sealed || !b)                     nxt = "hold";
      else if (phase == "bleed" && !pr)      nxt = "pump";
      else if (phase == "pump" && ev)        nxt = "done";
      else if (age == int'(MW) - 1)          nxt = "hold";
    end else begin
      if (!b) nxt = "idle";
    end
    if (nxt != phase) age = 0;
    else if (phase == "bleed" || phase == "pump") age++;
    phase = nxt;
  endtask

  task automatic step();
    @(posedge Clock);
    if (Reset) model_step();
    else begin
      phase = "idle";
      age   = 0;
    end
    #1;
  endtask

  // Directed vectors: {b, ic, oc, pr, ev, exp_dep, exp_evac}
  typedef struct {
    logic b, ic, oc, pr, ev, dep, evac;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [6:0] r, input int n);
    vec_t v;
    {v.b, v.ic, v.oc, v.pr, v.ev, v.dep, v.evac} = r;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    // full sequence
    add(7'b1111010, 1);  // DEPRESS
    add(7'b1110001, 1);  // EVAC
    add(7'b1110100, 1);  // DONE
    add(7'b0110100, 1);  // IDLE
    // interlock: outer door open
    add(7'b1101000, 5);
    add(7'b1111010, 1);  // door closes -> DEPRESS
    add(7'b1110001, 1);  // EVAC
    add(7'b1010000, 1);  // inner door drops -> HOLD
    add(7'b1110000, 2);  // re-closed, still HOLD
    add(7'b0110000, 1);  // IDLE
    add(7'b1110001, 1);  // skip straight to EVAC
    add(7'b0110000, 2);  // HOLD, IDLE
    add(7'b1111100, 2);  // already evacuated -> DONE
    add(7'b0111000, 1);  // IDLE
    // DEPRESS timeout: exactly MW cycles high
    add(7'b1111010, 4);
    add(7'b1111000, 1);  // HOLD
    add(7'b0111000, 1);  // IDLE
    // EVAC timeout
    add(7'b1110001, 4);
    add(7'b1110000, 1);
    add(7'b0110000, 1);
    // abort beats completion in EVAC
    add(7'b1110001, 1);
    add(7'b1010100, 1);
    add(7'b0110000, 1);
    // abort beats completion in DEPRESS
    add(7'b1111010, 1);
    add(7'b1100000, 1);
    add(7'b0111000, 1);
    // completion beats timeout in DEPRESS
    add(7'b1111010, 4);
    add(7'b1110001, 1);
    add(7'b0110000, 2);
    // completion beats timeout in EVAC
    add(7'b1110001, 4);
    add(7'b1110100, 1);
    add(7'b0110000, 1);
  end

  initial begin
    Reset = 1'b1;
    b = 1'b1; ic = 1'b1; oc = 1'b1; pr = 1'b1; ev = 1'b1;
    #1 Reset = 1'b0;
    #1;
    check("reset_async dep", dep, 1'b0);
    check("reset_async evac", evac, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold[%0d] dep", i), dep, 1'b0);
      check($sformatf("reset_hold[%0d] evac", i), evac, 1'b0);
    end
    b = 1'b0; ev = 1'b0;
    Reset = 1'b1;
    #1;
    check("reset_release dep", dep, 1'b0);
    check("reset_release evac", evac, 1'b0);
    step();
    check("post_reset dep", dep, 1'b0);
    check("post_reset evac", evac, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      b = vecs[i].b; ic = vecs[i].ic; oc = vecs[i].oc;
      pr = vecs[i].pr; ev = vecs[i].ev;
      step();
      check($sformatf("vec[%0d] dep", i), dep, vecs[i].dep);
      check($sformatf("vec[%0d] evac", i), evac, vecs[i].evac);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) b = ~b;
      ic = ($urandom_range(0, 15) != 0);
      oc = ($urandom_range(0, 15) != 0);
      pr = ($urandom_range(0, 3) != 0);
      ev = ($urandom_range(0, 5) == 0);
      step();
      check($sformatf("rand[%0d] dep", i), dep, (phase == "bleed"));
      check($sformatf("rand[%0d] evac", i), evac, (phase == "pump"));
      check($sformatf("rand[%0d] exclusive", i), dep & evac, 1'b0);
    end

    // reset in the middle of DEPRESS
    b = 1'b0;
    repeat (3) step();
    b = 1'b1; ic = 1'b1; oc = 1'b1; pr = 1'b1; ev = 1'b0;
    step();
    check("midreset_pre dep", dep, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("midreset_async dep", dep, 1'b0);
    check("midreset_async evac", evac, 1'b0);
    step();
    check("midreset_held dep", dep, 1'b0);
    Reset = 1'b1;
    #1;
    check("midreset_release dep", dep, 1'b0);
    step();
    check("midreset_restart dep", dep, (phase == "bleed"));
    check("midreset_restart evac", evac, (phase == "pump"));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
